// File: rtl/ct_spsram_ctrl_pkg.sv
// rtl/ct_spsram_ctrl_pkg.sv - shared widths and FSM encoding for the spsram controller
package ct_spsram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 9;
  localparam int unsigned SRAM_DATA_W = 54;
  localparam int unsigned SRAM_DEPTH  = 512;

  // FSM encoding kept as plain constants so legacy tools see the same values
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_INIT = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

endpackage

// File: rtl/ct_spsram_rsp_skid.sv
// rtl/ct_spsram_rsp_skid.sv - one-entry skid buffer for SRAM read responses
module ct_spsram_rsp_skid #(
  parameter int DATA_WIDTH = 54
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_pend,
  input  logic                  rsp_rdy,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  hold_vld,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Capture Q when the consumer stalls on the cycle it is valid; release on consume.
  // The controller blocks new reads while holding, so capture and release never collide.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (rd_pend && !rsp_rdy) begin
      hold_vld_d  = 1'b1;
      hold_data_d = sram_q;
    end else if (hold_vld_q && rsp_rdy) begin
      hold_vld_d  = 1'b0;
    end
  end

  // Skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_vld = hold_vld_q;
  assign rsp_vld  = rd_pend | hold_vld_q;
  assign rsp_data = hold_vld_q ? hold_data_q : sram_q;

endmodule

// File: rtl/ct_spsram_512x54_ctrl.sv
// rtl/ct_spsram_512x54_ctrl.sv - request/response and array-clear controller for ct_spsram_512x54
module ct_spsram_512x54_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = SRAM_ADDR_W,
  parameter int                    DATA_WIDTH  = SRAM_DATA_W,
  parameter int                    DEPTH       = SRAM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
  parameter bit                    INIT_ON_RST = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  init_req,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_pend_q, init_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
  logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;
  logic                  hold_vld;
  logic                  req_fire;

  // Accept only in RUN with no clear pending and room for the read data
  assign req_rdy  = (state_q == ST_RUN) & ~init_pend_q & ~init_req & ~hold_vld
                  & ~(rd_pend_q & ~rsp_rdy);
  assign req_fire = req_vld & req_rdy;
  assign init_done = (state_q == ST_RUN);

  // SRAM pin drive: init sweep, or same-cycle request decode; A/D hold when idle
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = sram_a_q;
    sram_d    = sram_d_q;
    if (state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
      sram_d    = INIT_VALUE;
    end else if (req_fire) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
        sram_d    = req_wdata;
      end
    end
    sram_a_d = sram_a;
    sram_d_d = sram_d;
  end

  // FSM, init counter and pending-clear bookkeeping
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_pend_d = init_pend_q;
    rd_pend_d   = req_fire & ~req_wr;
    case (state_q)
      ST_IDLE: state_d = INIT_ON_RST ? ST_INIT : ST_RUN;
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) init_pend_d = 1'b1;
        // Start the clear only once no read data is still owed to the consumer
        if (init_pend_q && !rd_pend_q && !hold_vld) begin
          state_d     = ST_INIT;
          init_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      init_cnt_q  <= '0;
      init_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      sram_a_q    <= '0;
      sram_d_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_pend_q <= init_pend_d;
      rd_pend_q   <= rd_pend_d;
      sram_a_q    <= sram_a_d;
      sram_d_q    <= sram_d_d;
    end
  end

  ct_spsram_rsp_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_skid (
    .clk      (forever_cpuclk),
    .rst_n    (cpurst_b),
    .rd_pend  (rd_pend_q),
    .rsp_rdy  (rsp_rdy),
    .sram_q   (sram_q),
    .hold_vld (hold_vld),
    .rsp_vld  (rsp_vld),
    .rsp_data (rsp_data)
  );

endmodule

// File: tb/tb_ct_spsram_512x54_ctrl.sv
// tb/tb_ct_spsram_512x54_ctrl.sv - self-checking bench for ct_spsram_512x54_ctrl
module tb_ct_spsram_512x54_ctrl;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        req_vld, req_rdy, req_wr;
  logic [8:0]  req_addr;
  logic [53:0] req_wdata, req_wmask;
  logic        rsp_vld, rsp_rdy;
  logic [53:0] rsp_data;
  logic        init_req, init_done;
  logic [8:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [53:0] sram_wen, sram_d;
  logic [53:0] sram_q;

  always #5 clk = ~clk;

  ct_spsram_512x54_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_data       (rsp_data),
    .init_req       (init_req),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural single-port SRAM on the sram_* pins
  logic [53:0] sram_mem [512];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  typedef struct {
    logic [53:0] data;
    int          cyc;
  } exp_t;

  logic [53:0] ref_mem [512];
  exp_t        exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        fired, rdy_s, strict_lat;
  logic [63:0] tmp64;
  logic [53:0] exp_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
  endtask

  // One clock: sample at negedge, update the reference model, then step past the edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    fired = req_vld && req_rdy;
    rdy_s = req_rdy;
    if (rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        if (strict_lat) check("rsp_latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
    if (fired) begin
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      else begin
        e.data = ref_mem[req_addr];
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_req(input logic wr, input logic [8:0] a, input logic [53:0] d, input logic [53:0] m);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
    fired = 1'b0;
    for (int k = 0; k < 50 && !fired; k++) tick();
    check("req_fire", 64'(fired), 64'd1);
    req_vld = 1'b0;
  endtask

  task automatic drain(input int n);
    rsp_rdy = 1'b1;
    for (int k = 0; k < n; k++) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
    check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'd0);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
    check({tag, "_cen"}, 64'(sram_cen), 64'd1);
    check({tag, "_gwen"}, 64'(sram_gwen), 64'd1);
    check({tag, "_wen"}, 64'(sram_wen), 64'h003F_FFFF_FFFF_FFFF);
    check({tag, "_a"}, 64'(sram_a), 64'd0);
    check({tag, "_d"}, 64'(sram_d), 64'd0);
  endtask

  // Wait (bounded) for INIT to start, check the 0..511 sweep, land at posedge+1 in RUN
  task automatic check_init_sweep(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (!sram_cen) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, "_start"}, 64'(ok), 64'd1);
    for (int i = 0; i < 512; i++) begin
      if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
      if (sram_a !== 9'(i) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || init_done !== 1'b0)
        check({tag, "_sweep"}, {sram_cen, sram_gwen, init_done, 52'(sram_a)}, {3'b000, 52'(i)});
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done"}, 64'(init_done), 64'd1);
    @(posedge clk); #1;
    ref_clear();
  endtask

  initial begin
    int idx, n_ops;
    logic ok;
    logic [8:0] addrs [3];
    logic [53:0] wd;
    cpurst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1; init_req = 1'b0;
    strict_lat = 1'b1; fired = 1'b0; rdy_s = 1'b0;
    ref_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    check_init_sweep("init0");

    // Top entry cleared by init
    do_req(1'b0, 9'h1FF, '0, '0);
    drain(2);

    // Full write then read-after-write
    do_req(1'b1, 9'h005, 54'h2A_5A5A_5A5A_5A5A, {54{1'b1}});
    do_req(1'b0, 9'h005, '0, '0);
    drain(2);

    // Partial write onto a zeroed entry
    do_req(1'b1, 9'h010, 54'h3F_FFFF_FFFF_FFFF, 54'h0000_0000_00FF);
    do_req(1'b0, 9'h010, '0, '0);
    drain(2);
    check("partial_ref", 64'(ref_mem[9'h010]), 64'h0000_0000_00FF);

    // Back-to-back reads under backpressure
    for (int i = 0; i < 3; i++) begin
      tmp64 = {$urandom(), $urandom()};
      do_req(1'b1, 9'(i), tmp64[53:0], {54{1'b1}});
    end
    addrs[0] = 9'd0; addrs[1] = 9'd1; addrs[2] = 9'd2;
    strict_lat = 1'b0;
    idx = 0;
    for (int c = 0; c < 30 && (idx < 3 || exp_q.size() > 0); c++) begin
      rsp_rdy = (c >= 3);
      req_vld = (idx < 3);
      req_wr = 1'b0;
      req_addr = addrs[idx < 3 ? idx : 2];
      tick();
      if (c == 1 || c == 2) check("stall_req_rdy", 64'(rdy_s), 64'd0);
      if (fired) idx++;
    end
    req_vld = 1'b0;
    check("b2b_all_fired", 64'(idx), 64'd3);
    drain(2);

    // Randomized traffic against the reference model
    n_ops = 0;
    for (int c = 0; c < 3000 && n_ops < 200; c++) begin
      if (!req_vld && $urandom_range(0, 3) != 0) begin
        req_vld = 1'b1;
        req_wr = 1'($urandom_range(0, 1));
        req_addr = 9'($urandom_range(0, 15));
        tmp64 = {$urandom(), $urandom()}; req_wdata = tmp64[53:0];
        tmp64 = {$urandom(), $urandom()}; req_wmask = tmp64[53:0];
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
      if (fired) begin n_ops++; req_vld = 1'b0; end
    end
    req_vld = 1'b0;
    check("rand_ops", 64'(n_ops), 64'd200);
    drain(4);

    // init_req while a read response is held
    do_req(1'b1, 9'h005, 54'h15_1234_5678_9ABC, {54{1'b1}});
    rsp_rdy = 1'b0;
    do_req(1'b0, 9'h005, '0, '0);
    init_req = 1'b1;
    tick();
    check("init_req_rdy", 64'(rdy_s), 64'd0);
    init_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("held_no_init", 64'(init_done), 64'd1);
    check("held_rsp_vld", 64'(rsp_vld), 64'd1);
    check("held_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    tick();
    check("held_popped", 64'(exp_q.size()), 64'd0);
    check_init_sweep("init1");
    strict_lat = 1'b1;
    for (int i = 0; i < 512; i++) do_req(1'b0, 9'(i), '0, '0);
    drain(2);

    // Reset in the middle of an init sweep
    do_req(1'b1, 9'h033, 54'h0A_BCDE_F012_3456, {54{1'b1}});
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 700 && !ok; k++) begin
      @(negedge clk);
      if (!sram_cen && sram_a == 9'd100) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("reach_cnt100", 64'(ok), 64'd1);
    cpurst_b = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    check_init_sweep("init2");
    wd = 54'h0;
    do_req(1'b0, 9'h000, '0, '0);
    do_req(1'b0, 9'h033, '0, '0);
    do_req(1'b0, 9'h1FF, '0, '0);
    drain(2);
    check("final_ref", 64'(ref_mem[9'h033]), 64'(wd));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
